sync_fifo_prog: RTL and testbench
=================================

SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, entry count; power of two, >=2.
REQ-003 SHALL have parameter FWFT, default 0; 0 = standard registered read, 1 = first-word-fall-through.
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: clr  in  1  synchronous flush; pointers, count and sticky flags cleared.
REQ-007 SHALL have ports: wr_en  in  1  write request; data_in  in  DWIDTH  write data.
REQ-008 SHALL have ports: rd_en  in  1  read request (pop).
REQ-009 SHALL have ports: af_thresh, ae_thresh  in  $clog2(DEPTH)+1  almost-full and almost-empty levels.
REQ-010 SHALL have ports: data_out  out  DWIDTH; rd_valid  out  1  data_out is valid.
REQ-011 SHALL have ports: empty, full, almost_empty, almost_full  out  1 each; numel  out  $clog2(DEPTH)+1  occupancy.
REQ-012 SHALL have ports: overflow, underflow  out  1  sticky error flags.

Function
REQ-013 SHALL accept a write when wr_en=1 and (!full or an accepted read in the same cycle); data stored at wr_ptr and wr_ptr advances.
REQ-014 SHALL accept a read when rd_en=1 and !empty; rd_ptr advances. A read never bypasses a same-cycle write into an empty FIFO.
REQ-015 SHALL wrap both pointers from DEPTH-1 to 0; numel SHALL be maintained as an explicit counter, 0..DEPTH.
REQ-016 SHALL update numel: +1 write only, -1 read only, unchanged for both or neither.
REQ-017 SHALL drive empty = (numel==0), full = (numel==DEPTH), almost_full = (numel>=af_thresh), almost_empty = (numel<=ae_thresh); all combinational from the registered count.
REQ-018 SHALL, when FWFT=0, register mem[rd_ptr] into data_out on the edge accepting a read and assert rd_valid for exactly the next cycle; data_out holds its value otherwise.
REQ-019 SHALL, when FWFT=1, present mem[rd_ptr] on data_out combinationally with rd_valid = !empty; rd_en pops the shown word.
REQ-020 SHALL set overflow on a rejected write (wr_en=1, full, no accepted read) and underflow on a rejected read (rd_en=1, empty); both stay set until rst or clr.
REQ-021 SHALL leave memory contents, pointers and count unchanged on any rejected request.
REQ-022 SHALL give clr priority over wr_en/rd_en in the same cycle; requests in that cycle are dropped without setting sticky flags.
REQ-023 SHALL support back-to-back read and write every cycle with no bubbles.

Reset
REQ-024 SHALL, on rst=1 at a rising edge, set wr_ptr=0, rd_ptr=0, numel=0, data_out=0, rd_valid=0, overflow=0, underflow=0; rst overrides clr and all requests.
REQ-025 SHALL not require memory array contents to be reset.
REQ-026 SHALL, after reset, present empty=1, full=0, almost_empty=1, almost_full=(af_thresh==0).

Structure
REQ-027 SHALL place the FWFT mode encoding and the count-width helper constant in shared package sync_fifo_pkg.
REQ-028 SHALL implement storage in one sub-module fifo_mem (DWIDTH x DEPTH register array, one synchronous write port, one asynchronous read port).
REQ-029 SHALL keep pointer, count, flag and output-register logic in sync_fifo_prog.

Verification
REQ-030 Fill/drain, DEPTH=8, FWFT=0: 8 writes 0x1000..0x1007 -> full=1, numel=8; 8 reads -> same order, each with a 1-cycle rd_valid pulse, then empty=1.
REQ-031 Overflow/underflow: 9th write while full -> overflow=1, numel=8, data unchanged; read while empty -> underflow=1; clr -> both 0, numel=0.
REQ-032 Simultaneous rd+wr: full, write 0xBEEF with a read -> numel stays 8, 0xBEEF read out last; empty with both -> write accepted, underflow=1, numel=1.
REQ-033 Thresholds af_thresh=6, ae_thresh=2: almost_empty drops at numel 3, almost_full rises at numel 6, toggling exactly at boundaries during fill and drain.
REQ-034 FWFT=1: write 0xA5A5 into empty FIFO -> next cycle data_out=0xA5A5, rd_valid=1 with no read; pop -> rd_valid=0.
REQ-035 Reset mid-operation: rst at numel=5 with wr_en=1 -> next cycle numel=0, empty=1, data_out=0, sticky flags 0; wrap test with 20 interleaved writes/reads preserves order.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the programmable-threshold synchronous FIFO.
package sync_fifo_pkg;

  typedef enum logic {
    FWFT_OFF = 1'b0,
    FWFT_ON  = 1'b1
  } fwft_mode_e;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit beyond the address width.
  function automatic int countWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// FIFO request/status bundle; the FIFO is the slave, its user is the master.
interface sync_fifo_prog_if
  import sync_fifo_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 8
);
  localparam int CW = countWidth(DEPTH);

  logic              clr;
  logic              wr_en;
  logic [DWIDTH-1:0] data_in;
  logic              rd_en;
  logic [CW-1:0]     af_thresh;
  logic [CW-1:0]     ae_thresh;
  logic [DWIDTH-1:0] data_out;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [CW-1:0]     numel;
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, wr_en, data_in, rd_en, af_thresh, ae_thresh,
    input  data_out, rd_valid, empty, full, almost_empty, almost_full,
           numel, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, data_in, rd_en, af_thresh, ae_thresh,
    output data_out, rd_valid, empty, full, almost_empty, almost_full,
           numel, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_prog_mem.sv
// Storage array for sync_fifo_prog: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DWIDTH-1:0] o_rdata
);

  logic [DWIDTH-1:0] r_mem [DEPTH];

  // Contents are deliberately left unreset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/empty levels, sticky error flags
// and a selectable registered or first-word-fall-through read side.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 8,
  parameter bit FWFT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_prog_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = countWidth(DEPTH);

  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [CW-1:0]     r_numel;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_empty;
  logic              w_full;
  logic              w_rdAccept;
  logic              w_wrAccept;
  logic              w_memWe;
  logic [DWIDTH-1:0] w_memRdata;

  assign w_empty    = (r_numel == '0);
  assign w_full     = (r_numel == CW'(DEPTH));
  // A write into a full FIFO is allowed only when a read frees a slot on the same edge.
  assign w_rdAccept = bus.rd_en && !w_empty;
  assign w_wrAccept = bus.wr_en && (!w_full || w_rdAccept);
  assign w_memWe    = w_wrAccept && !bus.clr && !rst;

  fifo_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_memWe),
    .i_waddr (r_wrPtr),
    .i_wdata (bus.data_in),
    .i_raddr (r_rdPtr),
    .o_rdata (w_memRdata)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_numel     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wrAccept) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_rdAccept) r_rdPtr <= r_rdPtr + 1'b1;
      if (w_wrAccept && !w_rdAccept) r_numel <= r_numel + CW'(1);
      else if (!w_wrAccept && w_rdAccept) r_numel <= r_numel - CW'(1);
      if (bus.wr_en && !w_wrAccept) r_overflow  <= 1'b1;
      if (bus.rd_en && !w_rdAccept) r_underflow <= 1'b1;
    end
  end

  assign bus.numel        = r_numel;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_full  = (r_numel >= bus.af_thresh);
  assign bus.almost_empty = (r_numel <= bus.ae_thresh);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

  if (fwft_mode_e'(FWFT) == FWFT_ON) begin : g_fwft
    assign bus.data_out = w_memRdata;
    assign bus.rd_valid = !w_empty;
  end else begin : g_regRead
    logic [DWIDTH-1:0] r_dataOut;
    logic              r_rdValid;

    // Data register only loads on an accepted pop; otherwise it holds the last word.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_dataOut <= '0;
        r_rdValid <= 1'b0;
      end else if (bus.clr) begin
        r_rdValid <= 1'b0;
      end else begin
        r_rdValid <= w_rdAccept;
        if (w_rdAccept) r_dataOut <= w_memRdata;
      end
    end

    assign bus.data_out = r_dataOut;
    assign bus.rd_valid = r_rdValid;
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: a registered-read and an FWFT instance driven in lockstep.
module tb_sync_fifo_prog;
  import sync_fifo_pkg::*;

  localparam int DWIDTH = 16;
  localparam int DEPTH  = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sync_fifo_prog_if #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) bus0 ();
  sync_fifo_prog_if #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) bus1 ();

  sync_fifo_prog #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .FWFT(1'b0)) u_dutReg (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  sync_fifo_prog #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .FWFT(1'b1)) u_dutFwft (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of requests into both FIFOs, then returns to idle 1 time unit after the edge.
  task automatic applyStimulus(input logic wr, input logic [DWIDTH-1:0] din,
                               input logic rd, input logic cl);
    bus0.wr_en = wr; bus0.data_in = din; bus0.rd_en = rd; bus0.clr = cl;
    bus1.wr_en = wr; bus1.data_in = din; bus1.rd_en = rd; bus1.clr = cl;
    @(posedge clk);
    #1;
    bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.clr = 1'b0;
    bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.clr = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.clr = 1'b0; bus0.data_in = '0;
    bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.clr = 1'b0; bus1.data_in = '0;
    bus0.af_thresh = 4'd6; bus0.ae_thresh = 4'd2;
    bus1.af_thresh = 4'd6; bus1.ae_thresh = 4'd2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("rst_empty",     32'(bus0.empty),        32'd1);
    checkOutput("rst_full",      32'(bus0.full),         32'd0);
    checkOutput("rst_aempty",    32'(bus0.almost_empty), 32'd1);
    checkOutput("rst_afull",     32'(bus0.almost_full),  32'd0);
    checkOutput("rst_numel",     32'(bus0.numel),        32'd0);
    checkOutput("rst_dout",      32'(bus0.data_out),     32'h0);
    checkOutput("rst_rdvalid",   32'(bus0.rd_valid),     32'd0);
    checkOutput("rst_ovf",       32'(bus0.overflow),     32'd0);
    checkOutput("rst_udf",       32'(bus0.underflow),    32'd0);
    checkOutput("rst_fwft_rdv",  32'(bus1.rd_valid),     32'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 16'(16'h1000 + i), 1'b0, 1'b0);
      checkOutput("fill_numel", 32'(bus0.numel),        32'(i + 1));
      checkOutput("fill_ae",    32'(bus0.almost_empty), 32'((i + 1) <= 2));
      checkOutput("fill_af",    32'(bus0.almost_full),  32'((i + 1) >= 6));
    end
    checkOutput("fill_full", 32'(bus0.full), 32'd1);

    applyStimulus(1'b1, 16'h9999, 1'b0, 1'b0);
    checkOutput("ovf_flag",  32'(bus0.overflow), 32'd1);
    checkOutput("ovf_numel", 32'(bus0.numel),    32'd8);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("drain_data",  32'(bus0.data_out),     32'(16'h1000 + i));
      checkOutput("drain_rdv",   32'(bus0.rd_valid),     32'd1);
      checkOutput("drain_numel", 32'(bus0.numel),        32'(7 - i));
      checkOutput("drain_ae",    32'(bus0.almost_empty), 32'((7 - i) <= 2));
      checkOutput("drain_af",    32'(bus0.almost_full),  32'((7 - i) >= 6));
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("idle_rdv",   32'(bus0.rd_valid), 32'd0);
    checkOutput("idle_hold",  32'(bus0.data_out), 32'h1007);
    checkOutput("idle_empty", 32'(bus0.empty),    32'd1);

    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("udf_flag",  32'(bus0.underflow), 32'd1);
    checkOutput("udf_rdv",   32'(bus0.rd_valid),  32'd0);
    checkOutput("udf_numel", 32'(bus0.numel),     32'd0);

    applyStimulus(1'b1, 16'h7777, 1'b1, 1'b1);
    checkOutput("clr_ovf",   32'(bus0.overflow),  32'd0);
    checkOutput("clr_udf",   32'(bus0.underflow), 32'd0);
    checkOutput("clr_numel", 32'(bus0.numel),     32'd0);

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'(16'h2000 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0);
    checkOutput("simul_numel", 32'(bus0.numel),    32'd8);
    checkOutput("simul_data",  32'(bus0.data_out), 32'h2000);
    checkOutput("simul_ovf",   32'(bus0.overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("simul_drain", 32'(bus0.data_out), (i < 7) ? 32'(16'h2001 + i) : 32'hBEEF);
    end

    applyStimulus(1'b1, 16'h3333, 1'b1, 1'b0);
    checkOutput("emptyboth_numel", 32'(bus0.numel),     32'd1);
    checkOutput("emptyboth_udf",   32'(bus0.underflow), 32'd1);
    checkOutput("emptyboth_rdv",   32'(bus0.rd_valid),  32'd0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("emptyboth_data",  32'(bus0.data_out),  32'h3333);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'(16'h5000 + i), 1'b0, 1'b0);
    checkOutput("mid_numel", 32'(bus0.numel), 32'd5);
    rst = 1'b1;
    applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("midrst_numel", 32'(bus0.numel),     32'd0);
    checkOutput("midrst_empty", 32'(bus0.empty),     32'd1);
    checkOutput("midrst_dout",  32'(bus0.data_out),  32'h0);
    checkOutput("midrst_udf",   32'(bus0.underflow), 32'd0);
    checkOutput("midrst_ovf",   32'(bus0.overflow),  32'd0);
    checkOutput("midrst_fnum",  32'(bus1.numel),     32'd0);

    applyStimulus(1'b1, 16'hA5A5, 1'b0, 1'b0);
    checkOutput("fwft_data", 32'(bus1.data_out), 32'hA5A5);
    checkOutput("fwft_rdv",  32'(bus1.rd_valid), 32'd1);
    checkOutput("reg_norv",  32'(bus0.rd_valid), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("fwft_hold", 32'(bus1.data_out), 32'hA5A5);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("fwft_pop_rdv", 32'(bus1.rd_valid), 32'd0);
    checkOutput("reg_pop_data", 32'(bus0.data_out), 32'hA5A5);

    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 16'(16'h4000 + k), (k > 0), 1'b0);
      checkOutput("wrap_numel", 32'(bus0.numel),    32'd1);
      checkOutput("wrap_fwft",  32'(bus1.data_out), 32'(16'h4000 + k));
      if (k > 0) checkOutput("wrap_data", 32'(bus0.data_out), 32'(16'h4000 + k - 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
